program_loader: RTL and testbench
=================================

# program_loader

Front-end writer for the program memory. Accepts ASCII characters one per handshake, encodes the eight Brainfuck commands into 4-bit opcodes and writes them sequentially from address 0. On `finish` it appends an END opcode and raises `PMInputDone` to release the control FSM. Optionally checks bracket balance before handing over.

## Interface

Parameters:
- `ADDR_W`, default 16. Program memory address width; matches the PC width.
- `DEPTH_W`, default 8. Bracket depth counter width; matches the BCount width.

Ports:
- `clock` input 1: single clock.
- `reset` input 1: synchronous, active-low.
- `charIn` input 8: ASCII character.
- `charValid` input 1: `charIn` is valid this cycle.
- `charReady` output 1: loader accepts a character this cycle.
- `finish` input 1: level request to end loading.
- `pmAddr` output ADDR_W: program memory write address.
- `pmData` output 4: opcode to write.
- `pmWren` output 1: program memory write enable, one-cycle pulse per write.
- `PMInputDone` output 1: program loaded and terminated; held high.
- `error` output 1: load aborted; held high.
- `errCode` output 2: error cause. 0 = none, 1 = unmatched `]`, 2 = unmatched `[`, 3 = memory full.
- `progLen` output ADDR_W: count of opcodes written, excluding END.

## Operation

- Opcode map: END=0, `>`=1, `<`=2, `+`=3, `-`=4, `.`=5, `,`=6, `[`=7, `]`=8. Every other byte is a comment: accepted and dropped, with no write and no counter change.
- States are LOAD, TERM, DONE, ERR. Reset enters LOAD with `progLen`=0 and depth=0.
- LOAD:
  - `charReady`=1.
  - Accept occurs when `charValid & charReady`.
  - Valid opcode accepted: write at `progLen`, then `progLen`++.
  - `[` increments depth.
  - `]` with depth=0 goes to ERR with code 1 and no write. Otherwise depth decrements.
  - Valid opcode with `progLen`=2^ADDR_W−1 goes to ERR with code 3 and no write. The last address is reserved for END.
  - Depth overflow saturates at 2^DEPTH_W−1. The next `[` goes to ERR with code 2.
- `finish` is sampled in LOAD only in cycles with no accept, so a character accepted in the same cycle wins.
  - On `finish` with depth≠0: go to ERR with code 2.
  - On `finish` otherwise: go to TERM.
- TERM: write END (0) at `progLen`, then go to DONE. `charReady`=0.
- DONE: `PMInputDone`=1 and `charReady`=0. Remains here until reset.
- ERR: `error`=1, `errCode` held, `charReady`=0, no writes. Remains here until reset.
- Reset mid-load (any state):
  - Next cycle is LOAD with all counters 0 and `pmWren`=0.
  - Partially written memory contents are not cleared.

## Timing

- All outputs are registered.
- Reset values: `charReady`=1 (LOAD), `pmAddr`=0, `pmData`=0, `pmWren`=0, `PMInputDone`=0, `error`=0, `errCode`=0, `progLen`=0.
- Throughput is one character per cycle in LOAD, with no bubbles.
- A character accepted at edge k produces `pmAddr`/`pmData`/`pmWren` valid during cycle k+1. `progLen` updates at edge k.
- `finish` seen at edge k:
  - state is TERM in cycle k+1;
  - the END write is visible in cycle k+2;
  - `PMInputDone` rises at edge k+2.
- Error detected at edge k: `error`/`errCode` are high from cycle k+1.
- `charReady` falls at the same edge that leaves LOAD, so no character is accepted after `finish` or error.

## Configuration

- `PLOAD_BRACKET_CHECK_EN` defined: the depth counter is present and error codes 1 and 2 are generated as above.
- `PLOAD_BRACKET_CHECK_EN` undefined:
  - no depth counter is built;
  - `[` and `]` are written like any other opcode;
  - `finish` always goes to TERM;
  - only code 3 (memory full) can occur.

## Test plan

- Stream `+[-].` then `finish` → writes (0,3),(1,7),(2,4),(3,8),(4,5),(5,0); `PMInputDone`=1; `progLen`=5; `error`=0.
- Stream `a+\n b` → a single write (0,3); `progLen`=1; comment bytes are accepted with `charReady` held high.
- Stream `]` → no write; `error`=1, `errCode`=1 next cycle; `charReady`=0.
- Stream `[[` then `finish` → `errCode`=2 and no END write. With `PLOAD_BRACKET_CHECK_EN` undefined, the same stimulus instead gives END at address 2 and `PMInputDone`=1.
- `ADDR_W`=2, stream `++++` → addresses 0–2 are written; the 4th `+` gives `errCode`=3 and no write to address 3.
- Stream `+++`, assert `reset` low for one cycle, then stream `-` and `finish` → writes (0,4),(1,0); `progLen`=1.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: encodes Brainfuck source bytes into 4-bit opcodes and writes program memory.
// Define PLOAD_BRACKET_CHECK_EN to build the bracket-depth checker (error codes 1 and 2).
module program_loader #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DEPTH_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        charIn,
    input  logic              charValid,
    output logic              charReady,
    input  logic              finish,
    output logic [ADDR_W-1:0] pmAddr,
    output logic [3:0]        pmData,
    output logic              pmWren,
    output logic              PMInputDone,
    output logic              error,
    output logic [1:0]        errCode,
    output logic [ADDR_W-1:0] progLen
);
    typedef enum logic [1:0] {StLoad, StTerm, StDone, StErr} stateT;

    // Last address is reserved for the END opcode.
    localparam logic [ADDR_W-1:0] LastAddr = '1;

    stateT             stateQ, stateD;
    logic [ADDR_W-1:0] progLenQ, progLenD;
    logic [ADDR_W-1:0] pmAddrQ, pmAddrD;
    logic [3:0]        pmDataQ, pmDataD;
    logic              pmWrenQ, pmWrenD;
    logic              doneQ, doneD;
    logic              errorQ, errorD;
    logic [1:0]        errCodeQ, errCodeD;
    logic              readyQ, readyD;
    logic [3:0]        opcode;
    logic              accept;
`ifdef PLOAD_BRACKET_CHECK_EN
    localparam logic [DEPTH_W-1:0] DepthMax = '1;
    logic [DEPTH_W-1:0] depthQ, depthD;
`endif

    always_comb begin
        opcode = 4'd0;
        case (charIn)
            8'h3E:   opcode = 4'd1;  // >
            8'h3C:   opcode = 4'd2;  // <
            8'h2B:   opcode = 4'd3;  // +
            8'h2D:   opcode = 4'd4;  // -
            8'h2E:   opcode = 4'd5;  // .
            8'h2C:   opcode = 4'd6;  // ,
            8'h5B:   opcode = 4'd7;  // [
            8'h5D:   opcode = 4'd8;  // ]
            default: opcode = 4'd0;
        endcase
    end

    assign accept = charValid & readyQ;

    always_comb begin
        stateD   = stateQ;
        progLenD = progLenQ;
        pmAddrD  = pmAddrQ;
        pmDataD  = pmDataQ;
        pmWrenD  = 1'b0;
        errorD   = errorQ;
        errCodeD = errCodeQ;
`ifdef PLOAD_BRACKET_CHECK_EN
        depthD   = depthQ;
`endif
        unique case (stateQ)
            StLoad: begin
                if (accept) begin
                    if (opcode != 4'd0) begin
`ifdef PLOAD_BRACKET_CHECK_EN
                        if (opcode == 4'd8 && depthQ == '0) begin
                            stateD   = StErr;
                            errorD   = 1'b1;
                            errCodeD = 2'd1;
                        end else if (opcode == 4'd7 && depthQ == DepthMax) begin
                            stateD   = StErr;
                            errorD   = 1'b1;
                            errCodeD = 2'd2;
                        end else
`endif
                        if (progLenQ == LastAddr) begin
                            stateD   = StErr;
                            errorD   = 1'b1;
                            errCodeD = 2'd3;
                        end else begin
                            pmAddrD  = progLenQ;
                            pmDataD  = opcode;
                            pmWrenD  = 1'b1;
                            progLenD = progLenQ + ADDR_W'(1);
`ifdef PLOAD_BRACKET_CHECK_EN
                            if (opcode == 4'd7) begin
                                depthD = depthQ + DEPTH_W'(1);
                            end else if (opcode == 4'd8) begin
                                depthD = depthQ - DEPTH_W'(1);
                            end
`endif
                        end
                    end
                end else if (finish) begin
`ifdef PLOAD_BRACKET_CHECK_EN
                    if (depthQ != '0) begin
                        stateD   = StErr;
                        errorD   = 1'b1;
                        errCodeD = 2'd2;
                    end else
`endif
                    stateD = StTerm;
                end
            end
            StTerm: begin
                pmAddrD = progLenQ;
                pmDataD = 4'd0;
                pmWrenD = 1'b1;
                stateD  = StDone;
            end
            default: ;
        endcase
        readyD = (stateD == StLoad);
        // Released one cycle after the END write so the memory has settled.
        doneD  = (stateQ == StDone);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            stateQ   <= StLoad;
            progLenQ <= '0;
            pmAddrQ  <= '0;
            pmDataQ  <= 4'd0;
            pmWrenQ  <= 1'b0;
            doneQ    <= 1'b0;
            errorQ   <= 1'b0;
            errCodeQ <= 2'd0;
            readyQ   <= 1'b1;
`ifdef PLOAD_BRACKET_CHECK_EN
            depthQ   <= '0;
`endif
        end else begin
            stateQ   <= stateD;
            progLenQ <= progLenD;
            pmAddrQ  <= pmAddrD;
            pmDataQ  <= pmDataD;
            pmWrenQ  <= pmWrenD;
            doneQ    <= doneD;
            errorQ   <= errorD;
            errCodeQ <= errCodeD;
            readyQ   <= readyD;
`ifdef PLOAD_BRACKET_CHECK_EN
            depthQ   <= depthD;
`endif
        end
    end

    assign charReady   = readyQ;
    assign pmAddr      = pmAddrQ;
    assign pmData      = pmDataQ;
    assign pmWren      = pmWrenQ;
    assign PMInputDone = doneQ;
    assign error       = errorQ;
    assign errCode     = errCodeQ;
    assign progLen     = progLenQ;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus random streams
// compared against a string-level reference model.
module tb_program_loader;
    localparam int AW    = 3;
    localparam int DW    = 2;
    localparam int MemSz = 1 << AW;
    localparam int MaxD  = (1 << DW) - 1;

    logic          clock;
    logic          reset;
    logic [7:0]    charIn;
    logic          charValid;
    logic          charReady;
    logic          finish;
    logic [AW-1:0] pmAddr;
    logic [3:0]    pmData;
    logic          pmWren;
    logic          PMInputDone;
    logic          error;
    logic [1:0]    errCode;
    logic [AW-1:0] progLen;

    int    nVec = 0;
    int    nErr = 0;
    string obsStr = "";
    bit    readyLow;

    string expW;
    int    expLen;
    bit    expDone;
    bit    expErr;
    int    expCode;

    program_loader #(.ADDR_W(AW), .DEPTH_W(DW)) dut (
        .clock       (clock),
        .reset       (reset),
        .charIn      (charIn),
        .charValid   (charValid),
        .charReady   (charReady),
        .finish      (finish),
        .pmAddr      (pmAddr),
        .pmData      (pmData),
        .pmWren      (pmWren),
        .PMInputDone (PMInputDone),
        .error       (error),
        .errCode     (errCode),
        .progLen     (progLen)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Write log as "(addr,data)" pairs, sampled mid-cycle.
    always @(negedge clock) begin
        if (pmWren === 1'b1) obsStr = {obsStr, $sformatf("(%0d,%0d)", pmAddr, pmData)};
    end

    task automatic model(input string s, input bit fin);
        string ops = "><+-.,[]";
        int    depth = 0;
        expW = ""; expLen = 0; expDone = 0; expErr = 0; expCode = 0;
        for (int i = 0; i < s.len() && !expErr; i++) begin
            int op = 0;
            for (int j = 0; j < ops.len(); j++) if (s[i] == ops[j]) op = j + 1;
            if (op == 0) continue;
`ifdef PLOAD_BRACKET_CHECK_EN
            if (op == 8 && depth == 0) begin expErr = 1; expCode = 1; break; end
            if (op == 7 && depth == MaxD) begin expErr = 1; expCode = 2; break; end
`endif
            if (expLen == MemSz - 1) begin expErr = 1; expCode = 3; break; end
            expW = {expW, $sformatf("(%0d,%0d)", expLen, op)};
            expLen++;
            if (op == 7) depth++;
            if (op == 8) depth--;
        end
        if (!expErr && fin) begin
`ifdef PLOAD_BRACKET_CHECK_EN
            if (depth != 0) begin expErr = 1; expCode = 2; end
`endif
            if (!expErr) begin
                expW = {expW, $sformatf("(%0d,0)", expLen)};
                expDone = 1;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0; charValid = 1'b0; finish = 1'b0; charIn = 8'h00;
        @(negedge clock);
        reset = 1'b1;
        obsStr = "";
    endtask

    task automatic stream_chars(input string s, input bit fin, input bit overlap);
        readyLow = 0;
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clock);
            if (charReady !== 1'b1) readyLow = 1;
            charIn = s[i];
            charValid = 1'b1;
            if (overlap && fin && i == s.len() - 1) finish = 1'b1;
        end
        @(negedge clock);
        charValid = 1'b0;
        finish = fin;
        repeat (5) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0; charValid = 1'b0; finish = 1'b0; charIn = 8'h00;
        repeat (2) @(negedge clock);
        nVec++; if (charReady !== 1'b1) begin nErr++; $display("FAIL reset charReady: got %b want 1", charReady); end
        nVec++; if (pmAddr !== '0) begin nErr++; $display("FAIL reset pmAddr: got %0d want 0", pmAddr); end
        nVec++; if (pmData !== 4'd0) begin nErr++; $display("FAIL reset pmData: got %0d want 0", pmData); end
        nVec++; if (pmWren !== 1'b0) begin nErr++; $display("FAIL reset pmWren: got %b want 0", pmWren); end
        nVec++; if (PMInputDone !== 1'b0) begin nErr++; $display("FAIL reset done: got %b want 0", PMInputDone); end
        nVec++; if (error !== 1'b0 || errCode !== 2'd0) begin nErr++; $display("FAIL reset error: got %b/%0d want 0/0", error, errCode); end
        nVec++; if (progLen !== '0) begin nErr++; $display("FAIL reset progLen: got %0d want 0", progLen); end
        reset = 1'b1;
        obsStr = "";
    endtask

    task automatic test_basic();
        apply_reset();
        stream_chars("+[-].", 1, 0);
        nVec++; if (obsStr != "(0,3)(1,7)(2,4)(3,8)(4,5)(5,0)") begin nErr++; $display("FAIL basic writes: got %s want (0,3)(1,7)(2,4)(3,8)(4,5)(5,0)", obsStr); end
        nVec++; if (PMInputDone !== 1'b1) begin nErr++; $display("FAIL basic done: got %b want 1", PMInputDone); end
        nVec++; if (progLen !== 3'd5) begin nErr++; $display("FAIL basic progLen: got %0d want 5", progLen); end
        nVec++; if (error !== 1'b0) begin nErr++; $display("FAIL basic error: got %b want 0", error); end
        nVec++; if (charReady !== 1'b0) begin nErr++; $display("FAIL basic charReady: got %b want 0", charReady); end
    endtask

    task automatic test_comments();
        apply_reset();
        stream_chars("a+\n b", 0, 0);
        nVec++; if (obsStr != "(0,3)") begin nErr++; $display("FAIL comment writes: got %s want (0,3)", obsStr); end
        nVec++; if (progLen !== 3'd1) begin nErr++; $display("FAIL comment progLen: got %0d want 1", progLen); end
        nVec++; if (readyLow !== 1'b0 || charReady !== 1'b1) begin nErr++; $display("FAIL comment charReady: got low=%b ready=%b want 0/1", readyLow, charReady); end
    endtask

    task automatic test_unmatched_close();
        apply_reset();
        @(negedge clock);
        charIn = 8'h5D; charValid = 1'b1;
        @(negedge clock);
        charValid = 1'b0;
`ifdef PLOAD_BRACKET_CHECK_EN
        nVec++; if (error !== 1'b1 || errCode !== 2'd1) begin nErr++; $display("FAIL close error: got %b/%0d want 1/1", error, errCode); end
        nVec++; if (charReady !== 1'b0) begin nErr++; $display("FAIL close charReady: got %b want 0", charReady); end
        nVec++; if (pmWren !== 1'b0) begin nErr++; $display("FAIL close pmWren: got %b want 0", pmWren); end
`else
        nVec++; if (error !== 1'b0) begin nErr++; $display("FAIL close error: got %b want 0", error); end
        nVec++; if (pmWren !== 1'b1 || pmData !== 4'd8) begin nErr++; $display("FAIL close write: got %b/%0d want 1/8", pmWren, pmData); end
`endif
        repeat (3) @(negedge clock);
    endtask

    task automatic test_unbalanced_finish();
        apply_reset();
        stream_chars("[[", 1, 0);
`ifdef PLOAD_BRACKET_CHECK_EN
        nVec++; if (obsStr != "(0,7)(1,7)") begin nErr++; $display("FAIL open writes: got %s want (0,7)(1,7)", obsStr); end
        nVec++; if (error !== 1'b1 || errCode !== 2'd2) begin nErr++; $display("FAIL open error: got %b/%0d want 1/2", error, errCode); end
        nVec++; if (PMInputDone !== 1'b0) begin nErr++; $display("FAIL open done: got %b want 0", PMInputDone); end
`else
        nVec++; if (obsStr != "(0,7)(1,7)(2,0)") begin nErr++; $display("FAIL open writes: got %s want (0,7)(1,7)(2,0)", obsStr); end
        nVec++; if (error !== 1'b0) begin nErr++; $display("FAIL open error: got %b want 0", error); end
        nVec++; if (PMInputDone !== 1'b1) begin nErr++; $display("FAIL open done: got %b want 1", PMInputDone); end
`endif
    endtask

    task automatic test_mem_full();
        apply_reset();
        stream_chars("++++++++", 0, 0);
        nVec++; if (obsStr != "(0,3)(1,3)(2,3)(3,3)(4,3)(5,3)(6,3)") begin nErr++; $display("FAIL full writes: got %s want addrs 0-6", obsStr); end
        nVec++; if (error !== 1'b1 || errCode !== 2'd3) begin nErr++; $display("FAIL full error: got %b/%0d want 1/3", error, errCode); end
        nVec++; if (progLen !== 3'd7) begin nErr++; $display("FAIL full progLen: got %0d want 7", progLen); end
    endtask

    task automatic test_reset_mid_load();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            charIn = 8'h2B; charValid = 1'b1;
        end
        @(negedge clock);
        charValid = 1'b0; reset = 1'b0;
        @(negedge clock);
        nVec++; if (pmWren !== 1'b0 || progLen !== '0 || charReady !== 1'b1) begin nErr++; $display("FAIL midreset state: got wren=%b len=%0d rdy=%b want 0/0/1", pmWren, progLen, charReady); end
        reset = 1'b1;
        obsStr = "";
        stream_chars("-", 1, 0);
        nVec++; if (obsStr != "(0,4)(1,0)") begin nErr++; $display("FAIL midreset writes: got %s want (0,4)(1,0)", obsStr); end
        nVec++; if (progLen !== 3'd1 || PMInputDone !== 1'b1) begin nErr++; $display("FAIL midreset end: got len=%0d done=%b want 1/1", progLen, PMInputDone); end
    endtask

    task automatic test_timing();
        apply_reset();
        @(negedge clock);
        charIn = 8'h2B; charValid = 1'b1;
        @(negedge clock);
        charValid = 1'b0; finish = 1'b1;
        nVec++; if (pmWren !== 1'b1 || pmAddr !== '0 || pmData !== 4'd3 || progLen !== 3'd1) begin nErr++; $display("FAIL timing write: got %b %0d %0d len=%0d want 1 0 3 len=1", pmWren, pmAddr, pmData, progLen); end
        @(negedge clock);
        nVec++; if (pmWren !== 1'b0 || charReady !== 1'b0 || PMInputDone !== 1'b0) begin nErr++; $display("FAIL timing term: got wren=%b rdy=%b done=%b want 0/0/0", pmWren, charReady, PMInputDone); end
        @(negedge clock);
        nVec++; if (pmWren !== 1'b1 || pmAddr !== 3'd1 || pmData !== 4'd0 || PMInputDone !== 1'b0) begin nErr++; $display("FAIL timing end: got %b %0d %0d done=%b want 1 1 0 done=0", pmWren, pmAddr, pmData, PMInputDone); end
        @(negedge clock);
        nVec++; if (PMInputDone !== 1'b1 || pmWren !== 1'b0) begin nErr++; $display("FAIL timing done: got done=%b wren=%b want 1/0", PMInputDone, pmWren); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        stream_chars("+-", 1, 1);
        nVec++; if (obsStr != "(0,3)(1,4)(2,0)") begin nErr++; $display("FAIL b2b writes: got %s want (0,3)(1,4)(2,0)", obsStr); end
        nVec++; if (progLen !== 3'd2 || PMInputDone !== 1'b1) begin nErr++; $display("FAIL b2b end: got len=%0d done=%b want 2/1", progLen, PMInputDone); end
    endtask

    task automatic test_random();
        string alpha = "><+-.,[]x ";
        for (int n = 0; n < 40; n++) begin
            string s = "";
            int    len = $urandom_range(0, 10);
            bit    fin = ($urandom_range(0, 3) != 0);
            bit    ovl = $urandom_range(0, 1) == 1;
            for (int i = 0; i < len; i++) begin
                int k = $urandom_range(0, alpha.len() - 1);
                s = {s, alpha.substr(k, k)};
            end
            model(s, fin);
            apply_reset();
            stream_chars(s, fin, ovl);
            nVec++; if (obsStr != expW) begin nErr++; $display("FAIL rand writes [%s]: got %s want %s", s, obsStr, expW); end
            nVec++; if (int'(progLen) != expLen) begin nErr++; $display("FAIL rand progLen [%s]: got %0d want %0d", s, progLen, expLen); end
            nVec++; if (PMInputDone !== expDone) begin nErr++; $display("FAIL rand done [%s]: got %b want %b", s, PMInputDone, expDone); end
            nVec++; if (error !== expErr || int'(errCode) != expCode) begin nErr++; $display("FAIL rand error [%s]: got %b/%0d want %b/%0d", s, error, errCode, expErr, expCode); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_comments();
        test_unmatched_close();
        test_unbalanced_finish();
        test_mem_full();
        test_reset_mid_load();
        test_timing();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
